srtsystem_receiver: RTL

Serial receiver for the Serial Transmission System: the far end of the existing 11-bit frame transmitter.
- Frame format: start(0), 8 data bits LSB first, parity, stop(1).
- Oversamples RXD on rxclk, recovers the data byte, and reports it with parity/framing/overrun status.
- Status is held until the consuming logic acknowledges it with a one-cycle RDACK pulse.

---
 rtl/srtsystem_receiver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/srtsystem_receiver.sv
// Oversampling serial receiver for 11-bit frames (start, 8 data LSB first, parity, stop).
// Optional macro RX_DEBUG_CNT_EN adds the extra_counter port (frame bit index).
module srtsystem_receiver #(
    parameter int BITNUM     = 11,
    parameter int DATAW      = 8,
    parameter int OVS        = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             rxclk,
    input  logic             clr,
    input  logic             RXD,
    input  logic             RDACK,
    output logic [DATAW-1:0] RXDATA,
    output logic             RXRDY,
    output logic             PERR,
    output logic             FERR,
    output logic             OVERRUN
`ifdef RX_DEBUG_CNT_EN
    ,
    output logic [3:0]       extra_counter
`endif
);

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(BITNUM + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATAW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             armed_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [DATAW-1:0] shift_q;
    logic             par_q;
    logic [DATAW-1:0] rxdata_q;
    logic             rxrdy_q;
    logic             perr_q;
    logic             ferr_q;
    logic             overrun_q;

    logic             rxd_s;
    logic             commit;
    logic             perr_calc;

    assign rxd_s     = sync2_q;
    assign commit    = (state_q == STOP) && (cnt_q == FULL_LAST);
    assign perr_calc = ((^shift_q) ^ par_q) != PARITY_ODD;

    always_ff @(posedge rxclk) begin
        if (!clr) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            rxdata_q  <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q <= RXD;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    // A line stuck low after a framing error must go high before re-arming.
                    if (rxd_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s, shift_q[DATAW-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        par_q     <= rxd_s;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        state_q   <= IDLE;
                        if (!rxd_s) begin
                            armed_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // An acknowledge on the commit edge frees the holding register for the new frame.
            if (commit) begin
                if (!rxrdy_q || RDACK) begin
                    rxdata_q  <= shift_q;
                    perr_q    <= perr_calc;
                    ferr_q    <= ~rxd_s;
                    rxrdy_q   <= 1'b1;
                    overrun_q <= RDACK ? 1'b0 : overrun_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (RDACK) begin
                rxrdy_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign RXDATA  = rxdata_q;
    assign RXRDY   = rxrdy_q;
    assign PERR    = perr_q;
    assign FERR    = ferr_q;
    assign OVERRUN = overrun_q;

`ifdef RX_DEBUG_CNT_EN
    assign extra_counter = 4'(bit_cnt_q);
`endif

endmodule
